// File: rtl/memory_access_unit_pkg.sv
// Shared definitions for the memory access unit:
// load/store width codes, result-source encoding and FSM states.
package mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Unknown funct3 codes fall back to a full word
  function automatic logic [1:0] access_size(input logic [2:0] f3);
    logic [1:0] sz;
    sz = SZ_W;
    unique case (1'b1)
      (f3 == LB) || (f3 == LBU): sz = SZ_B;
      (f3 == LH) || (f3 == LHU): sz = SZ_H;
      default:                   sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/memory_access_unit_if.sv
// Data-memory req/ack bus between the memory
// access unit (master) and data memory (slave).
interface memory_access_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/memory_access_unit_load_extend.sv
// Picks the addressed byte/half from a read word
// and sign- or zero-extends it by funct3.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_f3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    unique case (i_off)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
  end

  assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = i_word;
    unique case (1'b1)
      i_f3 == LB:  o_data = {{24{w_byte[7]}}, w_byte};
      i_f3 == LBU: o_data = {24'd0, w_byte};
      i_f3 == LH:  o_data = {{16{w_half[15]}}, w_half};
      i_f3 == LHU: o_data = {16'd0, w_half};
      default:     o_data = i_word;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// M-stage load/store engine: issues one req/ack bus
// transaction per access and stalls until it completes.
module memory_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [ADDR_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [2:0]            AddressingControlM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  MisalignedM,
  output logic                  BusErrM,
  memory_access_unit_if.master  bus
);

  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1
                    : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t r_state, w_next;

  logic                  r_req;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_off;
  logic [2:0]            r_f3;
  logic                  r_load;
  logic                  r_mis;
  logic                  r_buserr;
  logic [CW-1:0]         r_cnt;

  logic                  w_access;
  logic [1:0]            w_size;
  logic                  w_misal;
  logic                  w_start;
  logic                  w_timeout;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_ext;

  assign w_access = MemWriteM | (ResultSrcM == RESULT_SRC_MEM);
  assign w_size   = access_size(AddressingControlM);
  assign w_misal  = ((w_size == SZ_H) && ALUResultM[0]) ||
                    ((w_size == SZ_W) && (ALUResultM[1:0] != 2'b00));
  assign w_start  = (r_state == IDLE) && w_access && !w_misal;

  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteDataM;
    unique case (w_size)
      SZ_B: begin
        w_be    = 4'b0001 << ALUResultM[1:0];
        w_wdata = {4{WriteDataM[7:0]}};
      end
      SZ_H: begin
        w_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
      end
    endcase
  end

  load_extend u_ext (
    .i_word (bus.mem_rdata),
    .i_off  (r_off),
    .i_f3   (r_f3),
    .o_data (w_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    StallM = 1'b0;
    unique case (r_state)
      IDLE: begin
        StallM = w_start;
        if (w_start) w_next = BUSY;
      end
      BUSY: begin
        StallM = 1'b1;
        if (bus.mem_ack || w_timeout) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_be     <= 4'b0000;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_off    <= 2'b00;
      r_f3     <= 3'b000;
      r_load   <= 1'b0;
      r_mis    <= 1'b0;
      r_buserr <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_mis    <= 1'b0;
      r_buserr <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_access && w_misal) r_mis <= 1'b1;
          if (w_start) begin
            r_req   <= 1'b1;
            r_we    <= MemWriteM;
            r_addr  <= {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_off   <= ALUResultM[1:0];
            r_f3    <= AddressingControlM;
            r_load  <= !MemWriteM;
            r_cnt   <= '0;
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            r_req <= 1'b0;
            if (r_load) r_rdata <= w_ext;
          end else if (w_timeout) begin
            r_req    <= 1'b0;
            r_buserr <= 1'b1;
            r_rdata  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req   = r_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_be    = r_be;
  assign bus.mem_wdata = r_wdata;
  assign ReadDataM     = r_rdata;
  assign MisalignedM   = r_mis;
  assign BusErrM       = r_buserr;

endmodule
